// File: rtl/memory_access_pkg.sv
// rtl/memory_access_pkg.sv - shared op codes and FSM state encoding for the memory stage
package memory_access_pkg;

    typedef logic [1:0] op_t;
    typedef logic [1:0] state_t;

    localparam op_t OP_NOP   = 2'd0;
    localparam op_t OP_LOAD  = 2'd1;
    localparam op_t OP_STORE = 2'd2;
    localparam op_t OP_PASS  = 2'd3;

    localparam state_t ST_IDLE       = 2'd0;
    localparam state_t ST_READ       = 2'd1;
    localparam state_t ST_RESP       = 2'd2;
    localparam state_t ST_FAULT_RESP = 2'd3;

endpackage

// File: rtl/memory_access_if.sv
// rtl/memory_access_if.sv - execute-to-memory request and memory-to-writeback response bundle
interface memory_access_if;
    import memory_access_pkg::*;

    logic        ex_valid;
    logic        ex_ready;
    op_t         ex_op;
    logic [15:0] MAR;
    logic [15:0] MBR;
    logic [15:0] alu_result;
    logic        wb_valid;
    logic        wb_ready;
    logic [15:0] data_out;
    logic        wb_write_ac;
    logic        addr_fault;

    modport master (
        output ex_valid, ex_op, MAR, MBR, alu_result, wb_ready,
        input  ex_ready, wb_valid, data_out, wb_write_ac, addr_fault
    );

    modport slave (
        input  ex_valid, ex_op, MAR, MBR, alu_result, wb_ready,
        output ex_ready, wb_valid, data_out, wb_write_ac, addr_fault
    );

endinterface

// File: rtl/data_ram.sv
// rtl/data_ram.sv - single-port DEPTH x 16 RAM, synchronous read, write-first
module data_ram #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [15:0]       wdata_i,
    output logic [15:0]       rdata_o
);

    logic [15:0] mem [DEPTH];
    logic [15:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                mem[addr_i] <= wdata_i;
                rdata_q     <= wdata_i;
            end else begin
                rdata_q <= mem[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/memory_access.sv
// rtl/memory_access.sv - memory stage: LOAD/STORE/PASS to writeback with range fault and halt freeze
module memory_access
    import memory_access_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           halt_program,
    memory_access_if.slave bus
);

    if (DEPTH != 2 ** ADDR_W) begin : g_depth_check
        $error("memory_access: DEPTH must equal 2**ADDR_W");
    end

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         data_q, data_d;
    logic                wr_ac_q, wr_ac_d;
    logic                fault_q, fault_d;

    logic                accept;
    logic                in_range;
    logic                ram_we;
    logic                ram_re;
    logic [ADDR_W-1:0]   ram_addr;
    logic [15:0]         ram_rdata;

    assign bus.ex_ready = (state_q == ST_IDLE) && !halt_program;
    // An edge that still sees rst high must not write the RAM either.
    assign accept   = bus.ex_valid && bus.ex_ready && !rst;
    assign in_range = (bus.MAR >> ADDR_W) == 16'd0;

    assign ram_we   = accept && (bus.ex_op == OP_STORE) && in_range;
    // READ keeps re-issuing the read so a halt cannot lose the word.
    assign ram_re   = (accept && (bus.ex_op == OP_LOAD) && in_range) || (state_q == ST_READ);
    assign ram_addr = (state_q == ST_READ) ? addr_q : bus.MAR[ADDR_W-1:0];

    data_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_data_ram (
        .clk     (clk),
        .en_i    (ram_we || ram_re),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (bus.MBR),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = accept ? bus.MAR[ADDR_W-1:0] : addr_q;
        data_d  = data_q;
        wr_ac_d = wr_ac_q;
        fault_d = fault_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (((bus.ex_op == OP_LOAD) || (bus.ex_op == OP_STORE)) && !in_range) begin
                        state_d = ST_FAULT_RESP;
                        data_d  = 16'd0;
                        wr_ac_d = 1'b0;
                        fault_d = 1'b1;
                    end else if (bus.ex_op == OP_LOAD) begin
                        state_d = ST_READ;
                        wr_ac_d = 1'b1;
                    end else if (bus.ex_op == OP_STORE) begin
                        state_d = ST_RESP;
                        data_d  = bus.MBR;
                        wr_ac_d = 1'b0;
                    end else if (bus.ex_op == OP_PASS) begin
                        state_d = ST_RESP;
                        data_d  = bus.alu_result;
                        wr_ac_d = 1'b1;
                    end
                end
            end
            ST_READ: begin
                state_d = ST_RESP;
                data_d  = ram_rdata;
            end
            default: begin
                if (bus.wb_ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= 16'd0;
            wr_ac_q <= 1'b0;
            fault_q <= 1'b0;
        end else if (!halt_program) begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_ac_q <= wr_ac_d;
            fault_q <= fault_d;
        end
    end

    assign bus.wb_valid    = (state_q == ST_RESP) || (state_q == ST_FAULT_RESP);
    assign bus.data_out    = data_q;
    assign bus.wb_write_ac = wr_ac_q;
    assign bus.addr_fault  = fault_q;

endmodule

// File: tb/tb_memory_access.sv
// tb/tb_memory_access.sv - self-checking bench for memory_access with a behavioural memory model
module tb_memory_access;
    import memory_access_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic halt;

    memory_access_if bus ();

    memory_access #(.DEPTH(256), .ADDR_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .halt_program (halt),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic [15:0] model_mem [256];
    bit          model_known [256];
    bit          model_fault = 1'b0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one operation and returns just after its accept edge.
    task automatic accept_op(input op_t op, input logic [15:0] mar, input logic [15:0] mbr,
                             input logic [15:0] alu);
        int waited;
        bus.ex_valid   = 1'b1;
        bus.ex_op      = op;
        bus.MAR        = mar;
        bus.MBR        = mbr;
        bus.alu_result = alu;
        waited = 0;
        while (!bus.ex_ready && waited < 10) begin
            tick();
            waited++;
        end
        check("ex_ready_before_accept", {15'd0, bus.ex_ready}, 16'd1);
        tick();
        bus.ex_valid = 1'b0;
    endtask

    task automatic finish_resp(input int hold, input logic [15:0] exp_data);
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_wb_valid", {15'd0, bus.wb_valid}, 16'd1);
            check("hold_data_out", bus.data_out, exp_data);
            check("hold_ex_ready", {15'd0, bus.ex_ready}, 16'd0);
        end
        bus.wb_ready = 1'b1;
        tick();
        bus.wb_ready = 1'b0;
        check("after_hs_wb_valid", {15'd0, bus.wb_valid}, 16'd0);
        check("after_hs_ex_ready", {15'd0, bus.ex_ready}, 16'd1);
    endtask

    task automatic run_op(input op_t op, input logic [15:0] mar, input logic [15:0] mbr,
                          input logic [15:0] alu, input int hold);
        bit          inr;
        int          idx;
        int          exp_lat;
        int          lat;
        logic [15:0] exp_data;
        logic        exp_wr;
        bit          data_known;
        inr        = (mar < 16'd256);
        idx        = int'(mar & 16'h00FF);
        data_known = 1'b1;
        exp_data   = 16'd0;
        exp_wr     = 1'b0;
        exp_lat    = 1;
        accept_op(op, mar, mbr, alu);
        if (op == OP_NOP) begin
            for (int c = 0; c < 3; c++) begin
                check("nop_wb_valid", {15'd0, bus.wb_valid}, 16'd0);
                check("nop_ex_ready", {15'd0, bus.ex_ready}, 16'd1);
                tick();
            end
            return;
        end
        if (op != OP_PASS && !inr) begin
            model_fault = 1'b1;
        end else if (op == OP_PASS) begin
            exp_data = alu;
            exp_wr   = 1'b1;
        end else if (op == OP_STORE) begin
            exp_data         = mbr;
            model_mem[idx]   = mbr;
            model_known[idx] = 1'b1;
        end else begin
            exp_lat    = 2;
            exp_wr     = 1'b1;
            exp_data   = model_mem[idx];
            data_known = model_known[idx];
        end
        lat = 1;
        while (!bus.wb_valid && lat < 6) begin
            tick();
            lat++;
        end
        check("wb_latency", 16'(lat), 16'(exp_lat));
        if (data_known) check("data_out", bus.data_out, exp_data);
        check("wb_write_ac", {15'd0, bus.wb_write_ac}, {15'd0, exp_wr});
        check("addr_fault", {15'd0, bus.addr_fault}, {15'd0, model_fault});
        finish_resp(hold, bus.data_out);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [15:0] old_word;
        for (int i = 0; i < 256; i++) model_known[i] = 1'b0;
        rst = 1'b1;
        halt = 1'b0;
        bus.ex_valid = 1'b0;
        bus.ex_op = OP_NOP;
        bus.MAR = 16'd0;
        bus.MBR = 16'd0;
        bus.alu_result = 16'd0;
        bus.wb_ready = 1'b0;
        tick();
        tick();
        check("rst_wb_valid", {15'd0, bus.wb_valid}, 16'd0);
        check("rst_data_out", bus.data_out, 16'd0);
        check("rst_wb_write_ac", {15'd0, bus.wb_write_ac}, 16'd0);
        check("rst_addr_fault", {15'd0, bus.addr_fault}, 16'd0);
        check("rst_ex_ready", {15'd0, bus.ex_ready}, 16'd1);
        rst = 1'b0;
        tick();

        run_op(OP_STORE, 16'h0010, 16'hBEEF, 16'h0000, 0);
        run_op(OP_LOAD, 16'h0010, 16'h0000, 16'h0000, 0);
        run_op(OP_PASS, 16'h0000, 16'h0000, 16'h1234, 3);
        run_op(OP_NOP, 16'h0010, 16'h5555, 16'h6666, 0);

        run_op(OP_STORE, 16'h0030, 16'hA5A5, 16'h0000, 0);
        accept_op(OP_LOAD, 16'h0030, 16'h0000, 16'h0000);
        halt = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("halt_wb_valid", {15'd0, bus.wb_valid}, 16'd0);
            check("halt_ex_ready", {15'd0, bus.ex_ready}, 16'd0);
        end
        halt = 1'b0;
        tick();
        check("halt_release_wb_valid", {15'd0, bus.wb_valid}, 16'd1);
        check("halt_release_data", bus.data_out, 16'hA5A5);
        check("halt_release_wr_ac", {15'd0, bus.wb_write_ac}, 16'd1);
        finish_resp(0, 16'hA5A5);

        run_op(OP_LOAD, 16'h0100, 16'h0000, 16'h0000, 1);
        run_op(OP_STORE, 16'h8012, 16'h7777, 16'h0000, 0);
        run_op(OP_STORE, 16'h0011, 16'h0F0F, 16'h0000, 0);
        run_op(OP_PASS, 16'h0000, 16'h0000, 16'hFFFF, 0);

        for (int n = 0; n < 40; n++) begin
            op_t         op;
            logic [15:0] mar;
            op  = op_t'($urandom_range(0, 3));
            mar = 16'h0020 + 16'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) mar = mar | 16'h0400;
            run_op(op, mar, 16'($urandom), 16'($urandom), int'($urandom_range(0, 2)));
        end

        check("model_sticky_fault_seen", {15'd0, bus.addr_fault}, 16'd1);
        old_word = model_mem[16'h0010];
        accept_op(OP_LOAD, 16'h0010, 16'h0000, 16'h0000);
        rst = 1'b1;
        #1;
        check("midread_rst_wb_valid", {15'd0, bus.wb_valid}, 16'd0);
        check("midread_rst_data_out", bus.data_out, 16'd0);
        check("midread_rst_wr_ac", {15'd0, bus.wb_write_ac}, 16'd0);
        check("midread_rst_addr_fault", {15'd0, bus.addr_fault}, 16'd0);
        model_fault = 1'b0;
        bus.ex_valid = 1'b1;
        bus.ex_op = OP_STORE;
        bus.MAR = 16'h0010;
        bus.MBR = ~old_word;
        tick();
        rst = 1'b0;
        bus.ex_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("post_rst_wb_valid", {15'd0, bus.wb_valid}, 16'd0);
        end
        run_op(OP_LOAD, 16'h0010, 16'h0000, 16'h0000, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
